// File: rtl/viterbi_out_pkg.sv
// Shared constants, FSM states and buffer entry type for the output packer.
// Helpers: byte count per entry, bits in one output word, low-bit mask.
package viterbi_out_pkg;

    localparam int W_HALF = 32;
    localparam int W_FULL = 64;
    localparam int W_OUT  = 8;
    localparam int W_CNT  = 7;

    localparam logic [W_CNT-1:0] HALF_CNT = W_CNT'(W_HALF);
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(W_FULL);
    localparam logic [W_CNT-1:0] OUT_CNT  = W_CNT'(W_OUT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    typedef struct packed {
        logic [W_FULL-1:0] data;
        logic [W_CNT-1:0]  nbits;
        logic              last;
    } entry_t;

    function automatic logic [W_CNT-1:0] bytes_for(
        input logic [W_CNT-1:0] nbits
    );
        return W_CNT'((int'(nbits) + W_OUT - 1) / W_OUT);
    endfunction

    function automatic logic [3:0] word_bits(
        input logic [W_CNT-1:0] nbits
    );
        return (nbits >= OUT_CNT) ? 4'(W_OUT) : nbits[3:0];
    endfunction

    function automatic logic [W_FULL-1:0] low_mask(
        input logic [W_CNT-1:0] nbits
    );
        logic [W_FULL-1:0] m;
        for (int i = 0; i < W_FULL; i++) begin
            m[i] = (i < int'(nbits));
        end
        return m;
    endfunction

endpackage

// File: rtl/tb_output_packer_if.sv
// Byte-stream valid/ready bus leaving the output packer.
// Ports: dout_o, dout_valid_o, dout_last_o, dout_nbits_o, dout_ready_i.
interface tb_output_packer_if;
    import viterbi_out_pkg::*;

    logic [W_OUT-1:0] dout_o;
    logic             dout_valid_o;
    logic             dout_ready_i;
    logic             dout_last_o;
    logic [3:0]       dout_nbits_o;

    modport master (
        output dout_o,
        output dout_valid_o,
        output dout_last_o,
        output dout_nbits_o,
        input  dout_ready_i
    );

    modport slave (
        input  dout_o,
        input  dout_valid_o,
        input  dout_last_o,
        input  dout_nbits_o,
        output dout_ready_i
    );

endinterface

// File: rtl/tb_pingpong_buf.sv
// Two-entry FIFO of captured traceback words.
// Ports: clk_i, rst_sync_i, push_i/push_data_i, pop_i, head_o, count_o, full_o, overflow_o.
module tb_pingpong_buf
    import viterbi_out_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_sync_i,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       overflow_o
);

    entry_t     mem [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic [1:0] count_nxt;
    logic       full_r;
    logic       ovf_r;
    logic       do_push;
    logic       do_pop;

    // A push into a full buffer is dropped even if a pop happens too.
    assign do_push = push_i && (count_r != 2'd2);
    assign do_pop  = pop_i && (count_r != 2'd0);

    always_comb begin
        count_nxt = count_r;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count_r + 2'd1;
            2'b01:   count_nxt = count_r - 2'd1;
            default: count_nxt = count_r;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_r] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_r <= ~wr_ptr_r;
            if (do_pop)  rd_ptr_r <= ~rd_ptr_r;
            count_r <= count_nxt;
            full_r  <= (count_nxt == 2'd2);
            if (push_i && (count_r == 2'd2)) ovf_r <= 1'b1;
        end
    end

    assign head_o     = mem[rd_ptr_r];
    assign count_o    = count_r;
    assign full_o     = full_r;
    assign overflow_o = ovf_r;

endmodule

// File: rtl/tb_output_packer.sv
// Captures finished traceback words and serialises them LSB-first as bytes.
// Ports: traceback strobes/bits in, out_if byte stream, buf_full_o, overflow_o, frame_done_o.
module tb_output_packer
    import viterbi_out_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_sync_i,
    input  logic                segment_start_i,
    input  logic                decoding_end_i,
    input  logic [W_CNT-1:0]    final_bits_num_i,
    input  logic                tb_busy_i,
    input  logic                tb_bits_valid_i,
    input  logic [W_HALF-1:0]   half_tb_bits_i,
    input  logic [W_FULL-1:0]   full_tb_bits_i,
    tb_output_packer_if.master  out_if,
    output logic                buf_full_o,
    output logic                overflow_o,
    output logic                frame_done_o
);

    logic              busy_d_r;
    logic              seg_mode_r;
    logic [W_CNT-1:0]  seg_nbits_r;
    logic              capture;
    entry_t            cap_entry;
    entry_t            head;
    logic [1:0]        count;
    logic              pop;
    logic [W_CNT-1:0]  head_bytes;

    state_t            state_r;
    logic [W_FULL-1:0] shift_r;
    logic              ent_last_r;
    logic [W_CNT-1:0]  bytes_left_r;
    logic [W_CNT-1:0]  rem_r;

    // Falling edge of busy with stable bits marks a finished segment.
    assign capture = busy_d_r && !tb_busy_i && tb_bits_valid_i;

    always_comb begin
        cap_entry.last = seg_mode_r;
        if (seg_mode_r) begin
            cap_entry.data  = full_tb_bits_i & low_mask(seg_nbits_r);
            cap_entry.nbits = seg_nbits_r;
        end else begin
            cap_entry.data  = W_FULL'(half_tb_bits_i);
            cap_entry.nbits = HALF_CNT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            busy_d_r    <= 1'b0;
            seg_mode_r  <= 1'b0;
            seg_nbits_r <= '0;
        end else begin
            busy_d_r <= tb_busy_i;
            if (segment_start_i) begin
                seg_mode_r  <= decoding_end_i;
                seg_nbits_r <= (final_bits_num_i > FULL_CNT) ?
                               FULL_CNT : final_bits_num_i;
            end
        end
    end

    assign pop = (state_r == LOAD);

    tb_pingpong_buf u_buf (
        .clk_i       (clk_i),
        .rst_sync_i  (rst_sync_i),
        .push_i      (capture),
        .push_data_i (cap_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (buf_full_o),
        .overflow_o  (overflow_o)
    );

    assign head_bytes = bytes_for(head.nbits);

    // IDLE also reacts to a capture in flight so the first byte
    // appears two cycles after the capture.
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_r             <= IDLE;
            shift_r             <= '0;
            ent_last_r          <= 1'b0;
            bytes_left_r        <= '0;
            rem_r               <= '0;
            out_if.dout_o       <= '0;
            out_if.dout_valid_o <= 1'b0;
            out_if.dout_last_o  <= 1'b0;
            out_if.dout_nbits_o <= '0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (count != 2'd0 || capture) state_r <= LOAD;
                end
                LOAD: begin
                    shift_r      <= head.data;
                    ent_last_r   <= head.last;
                    bytes_left_r <= head_bytes;
                    rem_r        <= head.nbits;
                    if (head.nbits == '0) begin
                        state_r <= IDLE;
                    end else begin
                        out_if.dout_o       <= head.data[W_OUT-1:0];
                        out_if.dout_valid_o <= 1'b1;
                        out_if.dout_last_o  <= head.last &&
                                               (head_bytes == W_CNT'(1));
                        out_if.dout_nbits_o <= word_bits(head.nbits);
                        state_r             <= SEND;
                    end
                end
                SEND: begin
                    if (out_if.dout_valid_o && out_if.dout_ready_i) begin
                        if (bytes_left_r == W_CNT'(1)) begin
                            out_if.dout_valid_o <= 1'b0;
                            out_if.dout_last_o  <= 1'b0;
                            state_r <= (count != 2'd0) ? LOAD : IDLE;
                        end else begin
                            shift_r      <= shift_r >> W_OUT;
                            bytes_left_r <= bytes_left_r - W_CNT'(1);
                            rem_r        <= rem_r - OUT_CNT;
                            out_if.dout_o <= shift_r[2*W_OUT-1:W_OUT];
                            out_if.dout_last_o <= ent_last_r &&
                                (bytes_left_r == W_CNT'(2));
                            out_if.dout_nbits_o <= word_bits(rem_r - OUT_CNT);
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Frame ends when its last byte is taken, or when an empty final
    // entry is popped without producing any bytes.
    assign frame_done_o = !rst_sync_i && (
        ((state_r == SEND) && out_if.dout_valid_o &&
         out_if.dout_ready_i && out_if.dout_last_o) ||
        ((state_r == LOAD) && head.last && (head.nbits == '0)));

endmodule

// File: tb/tb_tb_output_packer.sv
// Bench for tb_output_packer: directed cases plus random segments,
// checked against a byte-queue model of the packer.
module tb_tb_output_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg_start = 1'b0;
    logic        dec_end = 1'b0;
    logic [6:0]  fbits = '0;
    logic        busy = 1'b0;
    logic        bvalid = 1'b0;
    logic [31:0] half_b = '0;
    logic [63:0] full_b = '0;
    logic        buf_full;
    logic        ovf;
    logic        fdone;

    tb_output_packer_if bus ();

    tb_output_packer dut (
        .clk_i            (clk),
        .rst_sync_i       (rst),
        .segment_start_i  (seg_start),
        .decoding_end_i   (dec_end),
        .final_bits_num_i (fbits),
        .tb_busy_i        (busy),
        .tb_bits_valid_i  (bvalid),
        .half_tb_bits_i   (half_b),
        .full_tb_bits_i   (full_b),
        .out_if           (bus),
        .buf_full_o       (buf_full),
        .overflow_o       (ovf),
        .frame_done_o     (fdone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         nb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    int   done_cnt = 0;
    bit   m_mode = 1'b0;
    int   m_nbits = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Split one captured word into the bytes the stream must carry.
    task automatic model_push(bit fin, int n, logic [63:0] d);
        int nb;
        nb = (n + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            exp_t e;
            int w;
            w = (fin && i == nb - 1) ? n - 8 * (nb - 1) : 8;
            e.d = 8'((d >> (8 * i)) & ((64'd1 << w) - 64'd1));
            e.last = fin && (i == nb - 1);
            e.nb = w;
            q.push_back(e);
        end
        if (fin) exp_frames++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fdone) done_cnt++;
            if (bus.dout_valid_o && bus.dout_ready_i) begin
                chk("byte_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("byte_data", 64'(bus.dout_o), 64'(e.d));
                    chk("byte_last", 64'(bus.dout_last_o), 64'(e.last));
                    chk("byte_nbits", 64'(bus.dout_nbits_o), 64'(e.nb));
                    chk("frame_done", 64'(fdone), 64'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.dout_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic start_busy(bit de, logic [6:0] fn, int n);
        seg_start = 1'b1;
        dec_end = de;
        fbits = fn;
        busy = 1'b1;
        bvalid = 1'b0;
        tick();
        m_mode = de;
        m_nbits = (int'(fn) > 64) ? 64 : int'(fn);
        seg_start = 1'b0;
        dec_end = 1'b0;
        repeat (n - 1) tick();
    endtask

    task automatic busy_only(int n);
        busy = 1'b1;
        repeat (n) tick();
    endtask

    // Busy falls with bits valid: one capture, optionally with a new
    // segment start in the same cycle.
    task automatic cap(bit st, bit de, logic [6:0] fn,
                       logic [31:0] h, logic [63:0] f, bit keep);
        busy = 1'b0;
        bvalid = 1'b1;
        half_b = h;
        full_b = f;
        seg_start = st;
        dec_end = de;
        fbits = fn;
        if (keep) begin
            if (m_mode) model_push(1'b1, m_nbits, f);
            else model_push(1'b0, 32, {32'd0, h});
        end
        tick();
        if (st) begin
            m_mode = de;
            m_nbits = (int'(fn) > 64) ? 64 : int'(fn);
        end
        bvalid = 1'b0;
        seg_start = 1'b0;
        dec_end = 1'b0;
    endtask

    task automatic do_seg(bit de, logic [6:0] fn, logic [31:0] h,
                          logic [63:0] f, int n, bit keep);
        start_busy(de, fn, n);
        cap(1'b0, 1'b0, 7'd0, h, f, keep);
    endtask

    task automatic wait_valid(string tag);
        for (int i = 0; i < 50; i++) begin
            if (bus.dout_valid_o) break;
            tick();
        end
        chk(tag, 64'(bus.dout_valid_o), 64'd1);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 1000; i++) begin
            if (q.size() == 0 && !bus.dout_valid_o) break;
            tick();
        end
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_dout"}, 64'(bus.dout_o), 64'd0);
        chk({tag, "_valid"}, 64'(bus.dout_valid_o), 64'd0);
        chk({tag, "_last"}, 64'(bus.dout_last_o), 64'd0);
        chk({tag, "_nbits"}, 64'(bus.dout_nbits_o), 64'd0);
        chk({tag, "_full"}, 64'(buf_full), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_done"}, 64'(fdone), 64'd0);
    endtask

    initial begin
        bus.dout_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Half segment, ready high: bytes from C+2 to C+5.
        bus.dout_ready_i = 1'b1;
        do_seg(1'b0, 7'd0, 32'h89AB_CDEF, 64'd0, 3, 1'b1);
        chk("lat_c1_valid", 64'(bus.dout_valid_o), 64'd0);
        tick();
        chk("lat_first_byte", 64'(bus.dout_o), 64'hEF);
        for (int i = 0; i < 4; i++) begin
            chk("lat_valid", 64'(bus.dout_valid_o), 64'd1);
            tick();
        end
        chk("lat_idle", 64'(bus.dout_valid_o), 64'd0);
        drain("drain_half");

        // Final segment of 13 bits with junk above bit 12.
        do_seg(1'b1, 7'd13, 32'd0, 64'hA5A5_5A5A_F00F_FFFF, 3, 1'b1);
        drain("drain_final13");
        tick();
        chk("frames_final13", 64'(done_cnt), 64'(exp_frames));

        // Stall for 10 cycles after the first byte is taken.
        bus.dout_ready_i = 1'b0;
        do_seg(1'b0, 7'd0, $urandom, 64'd0, 2, 1'b1);
        wait_valid("stall_valid");
        bus.dout_ready_i = 1'b1;
        tick();
        bus.dout_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid_hold", 64'(bus.dout_valid_o), 64'd1);
            chk("stall_dout", 64'(bus.dout_o), 64'(q[0].d));
            chk("stall_last", 64'(bus.dout_last_o), 64'(q[0].last));
            chk("stall_nbits", 64'(bus.dout_nbits_o), 64'(q[0].nb));
            tick();
        end
        bus.dout_ready_i = 1'b1;
        drain("drain_stall");

        // Stalled output: one word in the serialiser plus two buffered;
        // the fourth capture is dropped.
        bus.dout_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_seg(1'b0, 7'd0, $urandom, 64'd0, 1, k < 3);
            chk("ovf_full", 64'(buf_full), 64'(k >= 2));
            chk("ovf_flag", 64'(ovf), 64'(k == 3));
        end
        bus.dout_ready_i = 1'b1;
        drain("drain_ovf");
        chk("ovf_sticky", 64'(ovf), 64'd1);
        chk("ovf_full_clear", 64'(buf_full), 64'd0);

        // Segment start coinciding with a half capture.
        start_busy(1'b0, 7'd0, 2);
        cap(1'b1, 1'b1, 7'd20, 32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        busy_only(2);
        cap(1'b0, 1'b0, 7'd0, 32'hFFFF_FFFF, 64'h0000_0000_00AB_CDEF, 1'b1);
        drain("drain_same_cycle");
        tick();
        chk("frames_same_cycle", 64'(done_cnt), 64'(exp_frames));

        // Final segment carrying no bits.
        do_seg(1'b1, 7'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);
        repeat (4) tick();
        chk("zero_no_bytes", 64'(bus.dout_valid_o), 64'd0);
        chk("frames_zero", 64'(done_cnt), 64'(exp_frames));

        // Reset while a word is being sent.
        bus.dout_ready_i = 1'b0;
        do_seg(1'b0, 7'd0, 32'hCAFE_F00D, 64'd0, 2, 1'b1);
        wait_valid("rst_valid");
        rst = 1'b1;
        tick();
        chk_zero_outputs("midrst");
        rst = 1'b0;
        q.delete();
        m_mode = 1'b0;
        m_nbits = 0;
        tick();
        bus.dout_ready_i = 1'b1;
        do_seg(1'b1, 7'd64, 32'd0, {$urandom, $urandom}, 2, 1'b1);
        drain("drain_after_rst");
        tick();
        chk("frames_after_rst", 64'(done_cnt), 64'(exp_frames));

        // Random segments with random ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            do_seg(1'($urandom_range(0, 1)), 7'($urandom_range(0, 100)),
                   $urandom, {$urandom, $urandom},
                   int'($urandom_range(1, 4)), 1'b1);
            drain("drain_rand");
        end
        rand_rdy = 1'b0;
        bus.dout_ready_i = 1'b1;
        repeat (4) tick();
        chk("frames_total", 64'(done_cnt), 64'(exp_frames));
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
